spi_master_ctrl: RTL
====================

Name: spi_master_ctrl

Overview:
- SPI initiator (bus master) for the SPI link of the UART/SPI test chip. It drives cs_bar, sclk and mosi, and samples miso.
- Fixed format: SPI mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first by default.
- Accepts one byte per start pulse and returns the byte captured from miso with a done pulse.
- Serves as the counterpart to the on-chip SPI slave, both in loopback benches and in a future master-capable top.

Parameters:
- DATA_W, 8, frame width in bits. Only 8 is supported.
- DIV_BASE, 1, log2 of the smallest sclk half-period in clk cycles. Half-period H = 2^(DIV_BASE + freq_control).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- freq_control  input  2  sclk rate select; sampled only when start is accepted.
- start  input  1  single-cycle request; accepted only while busy=0.
- tx_data  input  8  byte to send; sampled when start is accepted.
- miso  input  1  serial data from the slave.
- cs_bar  output  1  active-low chip select.
- sclk  output  1  serial clock; idles low.
- mosi  output  1  serial data to the slave.
- busy  output  1  high from start acceptance until ready for the next start.
- done  output  1  one-cycle pulse when rx_data is valid.
- rx_data  output  8  last received byte; holds until the next done.

Behaviour:
- Reset values (rst_n=0, asynchronous): cs_bar=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0x00, FSM=IDLE. All counters clear.
- Reset mid-transfer aborts the frame immediately; no done pulse is issued.
- H = 2^(DIV_BASE+freq_control). With defaults: freq_control 0/1/2/3 gives H = 2/4/8/16 clk cycles. H is latched at start acceptance; later freq_control changes have no effect on the current frame.
- FSM states and transitions:
  - IDLE: cs_bar=1, sclk=0, busy=0. When start=1 at edge T0: latch tx_data into the shift register, latch H, go to SETUP.
  - SETUP: from T0+1, cs_bar=0, busy=1, mosi=tx_data[7]. Lasts H cycles, then go to XFER.
  - XFER: 16 sclk edges, spaced H cycles apart; the first rising edge is at T0+1+H.
    - Each rising edge: sample miso into the receive shift register (LSB side, shifting left).
    - Each falling edge except the 8th: shift mosi to the next bit.
    - After the 8th falling edge (T0+1+16H), go to HOLD with sclk=0 and mosi unchanged.
  - HOLD: cs_bar stays 0 for H cycles. At T0+1+17H: cs_bar=1, done=1 for exactly one cycle, rx_data loaded in that same cycle, go to GAP.
  - GAP: cs_bar=1, busy=1 for H cycles (minimum deselect time). At T0+1+18H: busy=0, go to IDLE.
- start while busy=1 is ignored; no queuing.
- start in the same cycle that busy falls is ignored; it is accepted from the first cycle busy=0 is observed.
- With defaults and freq_control=0: done asserts 35 cycles after T0 and busy deasserts at T0+37.
- mosi returns to 0 in IDLE. sclk never glitches; it is a registered output.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: mosi sends tx_data[0] first and shifts right. Received bits enter at the MSB side and shift right, so the first sampled bit ends in rx_data[0]. All timing is unchanged.
- Undefined: MSB first, exactly as described above.

Test Plan:
- Loopback (miso tied to mosi), freq_control=0, tx_data=0xA5 -> mosi sequence 1,0,1,0,0,1,0,1; rx_data=0xA5; done at T0+35; busy low at T0+37.
- miso=1 constant, freq_control=3, tx_data=0x00 -> sclk high/low each 16 cycles, 8 pulses; rx_data=0xFF; done at T0+273.
- Change freq_control 0->3 mid-frame, and pulse start again while busy -> frame timing still H=2; second start ignored; exactly one done.
- rst_n=0 asynchronously during the 4th bit -> same cycle: cs_bar=1, sclk=0, busy=0; no done; the next start transfers 0x3C correctly in loopback.
- Back-to-back: start on the first cycle busy=0 after the frame 0x12, then 0x34 -> cs_bar high for at least 2 cycles between frames; rx_data 0x12 then 0x34.
- SPI_LSB_FIRST_EN defined, loopback, tx_data=0x01 -> first mosi bit=1, remaining seven bits 0; rx_data=0x01.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one frame per accepted start, registered cs_bar/sclk/mosi, done pulse with rx_data.
// Define SPI_LSB_FIRST_EN to shift LSB first on both mosi and miso; timing is identical either way.
module spi_master_ctrl #(
  parameter int DATA_W   = 8,
  parameter int DIV_BASE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        freq_control,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              cs_bar,
  output logic              sclk,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);
  localparam int CNT_W = DIV_BASE + 4;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  hmax_q, hmax_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              cs_bar_q, cs_bar_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              phase_end;
  logic              tx_first;
  logic              mosi_next;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_next;

`ifdef SPI_LSB_FIRST_EN
  assign tx_first  = tx_data[0];
  assign mosi_next = tx_q[1];
  assign tx_shift  = tx_q >> 1;
  assign rx_next   = {miso, rx_q[DATA_W-1:1]};
`else
  assign tx_first  = tx_data[DATA_W-1];
  assign mosi_next = tx_q[DATA_W-2];
  assign tx_shift  = tx_q << 1;
  assign rx_next   = {rx_q[DATA_W-2:0], miso};
`endif

  // cnt_q counts clk cycles within the current half-period; hmax_q = H-1 latched at start
  assign phase_end = (cnt_q == hmax_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    hmax_d    = hmax_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    cs_bar_d  = cs_bar_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d  = S_SETUP;
          hmax_d   = (CNT_W'(1) << (DIV_BASE + int'(freq_control))) - CNT_W'(1);
          tx_d     = tx_data;
          mosi_d   = tx_first;
          cs_bar_d = 1'b0;
          busy_d   = 1'b1;
          bit_d    = '0;
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          state_d = S_XFER;
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = rx_next;
        end
      end
      S_XFER: begin
        if (phase_end) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q == LAST_BIT) begin
              state_d = S_HOLD;
            end else begin
              tx_d   = tx_shift;
              mosi_d = mosi_next;
              bit_d  = bit_q + BIT_W'(1);
            end
          end else begin
            sclk_d = 1'b1;
            rx_d   = rx_next;
          end
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          state_d   = S_GAP;
          cnt_d     = '0;
          cs_bar_d  = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_q;
        end
      end
      S_GAP: begin
        if (phase_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hmax_q    <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cs_bar_q  <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hmax_q    <= hmax_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      cs_bar_q  <= cs_bar_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cs_bar  = cs_bar_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
endmodule
